// File: rtl/mips_mc.sv
// Multi-cycle MIPS-I subset core. A single memory port is shared by instruction
// fetch and data access, sequenced by a six-state FSM over a 32x32 register file.
module mips_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc_o,
  output logic              retire,
  output logic              halt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc, ir, a, b, mdr, alu_out;
  logic            ovf_skip;
  logic [XLEN-1:0] rf [NREG];

  // Instruction fields
  logic [5:0]      op, funct;
  logic [RW-1:0]   rs, rt, rd;
  logic [15:0]     imm;
  logic [25:0]     target;
  logic            unused_shamt;

  assign op           = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign imm          = ir[15:0];
  assign target       = ir[25:0];
  assign unused_shamt = ^ir[10:6];

  logic [XLEN-1:0] simm, zimm, pc4, br_target, j_target, add_imm, npc, alu_c;
  logic            is_jr, ends_in_exec, is_mem, legal, addi_ovf;

  assign simm      = {{16{imm[15]}}, imm};
  assign zimm      = {16'h0000, imm};
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {simm[29:0], 2'b00};
  assign j_target  = {pc4[31:28], target, 2'b00};
  assign add_imm   = a + simm;
  assign addi_ovf  = (a[31] == simm[31]) && (add_imm[31] != a[31]);

  assign is_jr        = (op == OP_RTYPE) && (funct == FN_JR);
  assign ends_in_exec = (op == OP_BEQ) || (op == OP_J) || is_jr;
  assign is_mem       = (op == OP_LW) || (op == OP_SW);

  // Opcode/funct legality, evaluated in DECODE
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == FN_ADDU) || (funct == FN_SUBU) ||
                        (funct == FN_SLT)  || (funct == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // Next sequential/branch/jump PC; only meaningful once A/B are loaded
  always_comb begin
    npc = pc4;
    if ((op == OP_BEQ) && (a == b))       npc = br_target;
    else if ((op == OP_J) || (op == OP_JAL)) npc = j_target;
    else if (is_jr)                       npc = a;
  end

  always_comb begin
    alu_c = add_imm;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SUBU: alu_c = a - b;
          FN_SLT:  alu_c = XLEN'({31'h0, ($signed(a) < $signed(b))});
          default: alu_c = a + b;
        endcase
      end
      OP_ORI:  alu_c = a | zimm;
      OP_LUI:  alu_c = {imm, 16'h0000};
      default: alu_c = add_imm;
    endcase
  end

  logic [RW-1:0]   wb_dst;
  logic [XLEN-1:0] wb_data;
  logic            wb_en;

  assign wb_dst  = (op == OP_JAL) ? RW'(31) : ((op == OP_RTYPE) ? rd : rt);
  assign wb_data = (op == OP_LW) ? mdr : ((op == OP_JAL) ? pc4 : alu_out);
  assign wb_en   = (state == WB) && !ovf_skip && (wb_dst != RW'(0));

  // Completion strobe: must coincide with the cycle the FSM heads back to FETCH
  assign retire = (state == WB) ||
                  ((state == EXEC) && ends_in_exec) ||
                  ((state == MEM) && mem_ack && mem_we);

  assign pc_o = pc;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [XLEN-1:0] x);
    return ADDR_W'({x[XLEN-1:2], 2'b00});
  endfunction

  // Control FSM; bus outputs are loaded with the values of the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      mdr       <= '0;
      alu_out   <= '0;
      ovf_skip  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= word_addr(RESET_PC);
      mem_wdata <= '0;
      halt      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DECODE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_addr(pc);
          end
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          if (legal) begin
            state <= EXEC;
          end else begin
            state <= HALT;
            halt  <= 1'b1;
          end
        end
        EXEC: begin
          alu_out  <= alu_c;
          ovf_skip <= (op == OP_ADDI) && addi_ovf;
          if (is_mem) begin
            state     <= MEM;
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_SW);
            mem_addr  <= word_addr(add_imm);
            mem_wdata <= b;
          end else if (ends_in_exec) begin
            pc       <= npc;
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_addr(npc);
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (mem_we) begin
              pc       <= npc;
              state    <= FETCH;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(npc);
            end else begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= WB;
            end
          end
        end
        WB: begin
          pc       <= npc;
          state    <= FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= word_addr(npc);
        end
        HALT: begin
          halt    <= 1'b1;
          mem_req <= 1'b0;
        end
        default: begin
          state <= HALT;
          halt  <= 1'b1;
        end
      endcase
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[RW'(i)] <= '0;
    end else if (wb_en) begin
      rf[wb_dst] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_mc.sv
// Directed bench for mips_mc: small program images behind a latency-configurable
// memory responder, with hand-computed register, bus and timing expectations.
module tb_mips_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] LOOP = 32'h1000FFFF;

  logic [31:0] prog [0:63];
  logic [31:0] dmem [0:15];
  int          ack_delay;
  int          ack_cnt;

  int          cyc;
  int          ret_q [$];
  int          fc_q  [$];
  logic [31:0] fa_q  [$];
  int          wr_cnt, req_cycles, stab_err;
  logic [31:0] wr_addr, wr_data;
  logic        prev_wait, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  always #5 clk = ~clk;

  mips_mc #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_o      (pc_o),
    .retire    (retire),
    .halt      (halt)
  );

  assign mem_ack   = mem_req && (ack_cnt == ack_delay);
  assign mem_rdata = (mem_addr >= 32'h3000) ? prog[mem_addr[7:2]] : dmem[mem_addr[5:2]];

  // Memory responder: request age counter and data writes
  always @(posedge clk) begin
    if (!rst || !mem_req || mem_ack) ack_cnt <= 0;
    else                             ack_cnt <= ack_cnt + 1;
    if (!rst) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
    end else if (mem_req && mem_ack && mem_we) begin
      dmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  // Bus/retire monitor; cycle 1 is the first cycle after reset release
  always @(negedge clk) begin
    if (!rst) begin
      cyc = 0;
      ret_q.delete();
      fc_q.delete();
      fa_q.delete();
      wr_cnt = 0;
      req_cycles = 0;
      stab_err = 0;
      prev_wait = 1'b0;
    end else begin
      cyc++;
      if (retire) ret_q.push_back(cyc);
      if (mem_req) req_cycles++;
      if (mem_req && mem_ack && !mem_we) begin
        fa_q.push_back(mem_addr);
        fc_q.push_back(cyc);
      end
      if (mem_req && mem_ack && mem_we) begin
        wr_cnt++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
      if (prev_wait && (!mem_req || mem_we !== prev_we || mem_addr !== prev_addr ||
                        mem_wdata !== prev_wdata)) stab_err++;
      prev_wait  = mem_req && !mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  function automatic logic [31:0] ret_at(input int i);
    return (i < ret_q.size()) ? 32'(ret_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] fc_at(input int i);
    return (i < fc_q.size()) ? 32'(fc_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] fa_at(input int i);
    return (i < fa_q.size()) ? fa_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_prog();
    for (int i = 0; i < 64; i++) prog[i] = LOOP;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int rq;

  initial begin
    rst       = 1'b0;
    ack_delay = 0;
    fill_prog();

    // Reset values
    run(2);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_retire",  32'(retire),  32'd0);
    check("rst_halt",    32'(halt),    32'd0);
    check("rst_pc",      pc_o,         32'h3000);

    // ori $1,$0,0x1234 ; addu $2,$1,$1 (zero wait)
    prog[0] = 32'h34011234;
    prog[1] = 32'h00211021;
    do_reset();
    run(1);
    check("first_req",  32'(mem_req), 32'd1);
    check("first_addr", mem_addr,     32'h3000);
    run(11);
    check("a_ret0", ret_at(0), 32'd4);
    check("a_ret1", ret_at(1), 32'd8);
    check("a_r1",   dut.rf[1], 32'h1234);
    check("a_r2",   dut.rf[2], 32'h2468);

    // sw/lw with three wait cycles per access
    fill_prog();
    prog[0]   = 32'h34022468;
    prog[1]   = 32'hAC020000;
    prog[2]   = 32'h8C030000;
    ack_delay = 3;
    do_reset();
    run(40);
    check("b_wr_cnt",  32'(wr_cnt), 32'd1);
    check("b_wr_addr", wr_addr,     32'h0);
    check("b_wr_data", wr_data,     32'h2468);
    check("b_r3",      dut.rf[3],   32'h2468);
    check("b_ret_ori", ret_at(0),   32'd7);
    check("b_ret_sw",  ret_at(1),   32'd17);
    check("b_ret_lw",  ret_at(2),   32'd28);
    check("b_stable",  32'(stab_err), 32'd0);

    // beq $0,$0,-1 self loop
    fill_prog();
    ack_delay = 0;
    do_reset();
    run(8);
    check("c_fc0", fc_at(0), 32'd1);
    check("c_fc1", fc_at(1), 32'd4);
    check("c_fc2", fc_at(2), 32'd7);
    check("c_fa2", fa_at(2), 32'h3000);

    // ori ; jal 0x3010 ; (0x3010) jr $31 -> 0x3008 loop
    fill_prog();
    prog[0] = 32'h34050001;
    prog[1] = 32'h0C000C04;
    prog[4] = 32'h03E00008;
    do_reset();
    run(20);
    check("j_fa1", fa_at(1),   32'h3004);
    check("j_fa2", fa_at(2),   32'h3010);
    check("j_fa3", fa_at(3),   32'h3008);
    check("j_fc3", fc_at(3),   32'd12);
    check("j_r31", dut.rf[31], 32'h3008);

    // Overflow-suppressed addi, signed slt, subu, negative addi
    fill_prog();
    prog[0] = 32'h3C017FFF;
    prog[1] = 32'h3421FFFF;
    prog[2] = 32'h20220001;
    prog[3] = 32'h0020202A;
    prog[4] = 32'h00012823;
    prog[5] = 32'h00A0302A;
    prog[6] = 32'h2007FFFE;
    do_reset();
    run(32);
    check("d_r1",      dut.rf[1], 32'h7FFF_FFFF);
    check("d_r2_ovf",  dut.rf[2], 32'h0);
    check("d_ret_ovf", ret_at(2), 32'd12);
    check("d_r4",      dut.rf[4], 32'h0);
    check("d_r5",      dut.rf[5], 32'h8000_0001);
    check("d_r6",      dut.rf[6], 32'h1);
    check("d_r7",      dut.rf[7], 32'hFFFF_FFFE);

    // Illegal opcode 0x3F at 0x300C halts
    fill_prog();
    prog[0] = 32'h34010001;
    prog[1] = 32'h34020002;
    prog[2] = 32'h34030003;
    prog[3] = 32'hFC000000;
    do_reset();
    run(30);
    check("e_halt",    32'(halt),    32'd1);
    check("e_pc",      pc_o,         32'h300C);
    check("e_req",     32'(mem_req), 32'd0);
    check("e_retire",  32'(retire),  32'd0);
    check("e_fa3",     fa_at(3),     32'h300C);
    check("e_r3",      dut.rf[3],    32'h3);
    rq = req_cycles;
    run(10);
    check("e_no_req", 32'(req_cycles), 32'(rq));

    // Reset releases halt and restarts fetch; a reset mid-fetch abandons it
    ack_delay = 4;
    do_reset();
    run(1);
    check("r_req",  32'(mem_req), 32'd1);
    check("r_addr", mem_addr,     32'h3000);
    check("r_halt", 32'(halt),    32'd0);
    run(1);
    rst = 1'b0;
    #1;
    check("r_abort_req", 32'(mem_req), 32'd0);
    check("r_abort_pc",  pc_o,         32'h3000);
    check("r_abort_r1",  dut.rf[1],    32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_mc.md
MIPS_MC -- requirements
Module: mips_mc

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the address of the first fetch after reset.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning the width of mem_addr (valid range 12..32); it carries byte address bits [ADDR_W-1:0].
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port mem_req  output  1  SHALL mean a memory access is requested.
REQ-006 Port mem_we  output  1  SHALL mean the request is a word write (1) or a read (0).
REQ-007 Port mem_addr  output  ADDR_W  SHALL be the word-aligned byte address; bits [1:0] are always 0.
REQ-008 Port mem_wdata  output  32  SHALL be the write data.
REQ-009 Port mem_rdata  input  32  SHALL be the read data, valid in the cycle mem_ack=1.
REQ-010 Port mem_ack  input  1  SHALL mean the current request completes this cycle.
REQ-011 Port pc_o  output  32  SHALL be the architectural PC of the instruction in progress.
REQ-012 Port retire  output  1  SHALL be a one-cycle pulse when an instruction completes.
REQ-013 Port halt  output  1  SHALL mean the core has stopped on an unsupported instruction.

Function
REQ-014 The core SHALL be a multi-cycle MIPS-I subset: addu, subu, slt, jr, addi, ori, lui, lw, sw, beq, j, jal; 32x32 register file, $0 reads 0 and ignores writes.
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: req=1, we=0, addr=PC; on ack, latch IR, go DECODE.
- DECODE: read rs/rt into A/B; illegal opcode/funct -> HALT.
- EXEC: ALU/branch/jump resolve; lw/sw -> MEM; beq, j, jr -> FETCH; others -> WB.
- MEM: req=1, addr=A+sext(imm); sw: we=1, wdata=B, on ack -> FETCH; lw: on ack latch MDR, go WB.
- WB: write register, go FETCH.
REQ-016 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable from assertion until the cycle mem_ack=1 (inclusive); ack with req=0 SHALL be ignored.
REQ-017 With zero-wait ack (ack in the same cycle as req) latency SHALL be: beq/j/jr 3 cycles; addu/subu/slt/addi/ori/lui/sw/jal 4; lw 5; each wait cycle adds 1.
REQ-018 PC update: sequential PC+4; beq taken PC+4+(sext(imm)<<2); j/jal {PC+4[31:28],target,2'b00}; jr A; PC wraps modulo 2^32.
REQ-019 jal SHALL write PC+4 into $31; slt SHALL be signed compare, writing 1 or 0.
REQ-020 ori SHALL zero-extend; addi, lw, sw, beq SHALL sign-extend; lui SHALL write {imm,16'h0}.
REQ-021 addi with signed overflow SHALL skip the register write but still retire; addu/subu never trap.
REQ-022 retire SHALL pulse in the cycle the FSM leaves EXEC, MEM or WB toward FETCH.
REQ-023 HALT SHALL be terminal until reset: halt=1, mem_req=0, retire=0, pc_o holds the offending PC.

Reset
REQ-024 While rst=0: state=FETCH, PC=RESET_PC, all GPRs=0, IR/A/B/MDR=0, mem_req=0, mem_we=0, retire=0, halt=0, pc_o=RESET_PC.
REQ-025 The first mem_req SHALL assert in the first cycle after rst deasserts; a reset mid-access SHALL abandon the access with no register or PC side effect.

Verification
REQ-026 ori $1,$0,0x1234 then addu $2,$1,$1 with zero-wait memory -> $2=0x2468, retire pulses at cycles 4 and 8.
REQ-027 sw $2,0($0) then lw $3,0($0), ack delayed 3 cycles per access -> write at addr 0 with data 0x2468, $3=0x2468, lw takes 5+6 cycles.
REQ-028 beq $0,$0,-1 at 0x3000 -> fetch repeats at 0x3000 every 3 cycles; jal 0x3010 at 0x3004 -> $31=0x3008, next fetch 0x3010.
REQ-029 lui $1,0x7FFF; ori $1,$1,0xFFFF; addi $2,$1,1 -> $2 unchanged (0), retire still pulses; slt $4,$1,$0 -> $4=0.
REQ-030 Opcode 6'h3F fetched at 0x300C -> halt=1, pc_o=0x300C, no further mem_req; rst=0 then 1 -> fetch restarts at 0x3000.
